issp_vec_engine: RTL and testbench

ISSP_VEC_ENGINE -- requirements
Module: issp_vec_engine

---
 rtl/issp_vec_engine_if.sv | 29 ++
 rtl/issp_vec_engine.sv | 156 +++++++++++++++
 tb/tb_issp_vec_engine.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/issp_vec_engine_if.sv
// rtl/issp_vec_engine_if.sv - command/status bundle between host and ISSP vector engine
interface issp_vec_engine_if #(
  parameter int VEC_W = 22,
  parameter int DLY_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd;
  logic [VEC_W-1:0] vec_in;
  logic [VEC_W-1:0] mask_in;
  logic [6:0]       vec_len;
  logic [DLY_W-1:0] half_dly;
  logic [DLY_W-1:0] tmo_lim;
  logic             abort;
  logic             busy;
  logic             done;
  logic             err;
  logic [VEC_W-1:0] rx_vec;

  modport master (
    output cmd_valid, cmd, vec_in, mask_in, vec_len, half_dly, tmo_lim, abort,
    input  cmd_ready, busy, done, err, rx_vec
  );

  modport slave (
    input  cmd_valid, cmd, vec_in, mask_in, vec_len, half_dly, tmo_lim, abort,
    output cmd_ready, busy, done, err, rx_vec
  );
endinterface

// File: rtl/issp_vec_engine.sv
// rtl/issp_vec_engine.sv - ISSP vector engine: Vdd power-on sequencing, SCLK/SDATA bit cells, EXEC polling
module issp_vec_engine #(
  parameter int VEC_W     = 22,
  parameter int DLY_W     = 16,
  parameter int POR_WAIT  = 12000,
  parameter int EXEC_CLKS = 40
) (
  input  logic             osc,
  input  logic             rst_n,
  issp_vec_engine_if.slave bus,
  input  logic             sdata_in,
  output logic             sdata_out,
  output logic             sdata_oe,
  output logic             sclk_out,
  output logic             sclk_oe,
  output logic             vdd_en
);
  localparam int IW = $clog2(VEC_W);
  localparam int PW = $clog2(POR_WAIT + 2);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_VDD_ON  = 4'd1;
  localparam logic [3:0] ST_WAIT_HI = 4'd2;
  localparam logic [3:0] ST_WAIT_LO = 4'd3;
  localparam logic [3:0] ST_SHIFT   = 4'd4;
  localparam logic [3:0] ST_PRE     = 4'd5;
  localparam logic [3:0] ST_POLL    = 4'd6;
  localparam logic [3:0] ST_TRAIL   = 4'd7;
  localparam logic [3:0] ST_NOP     = 4'd8;
  localparam logic [3:0] ST_DONE    = 4'd9;

  logic [3:0]       state;
  logic [VEC_W-1:0] vec, mask, rx_vec, keep;
  logic [DLY_W-1:0] h_m1, tmo_lim_q, cnt, tmo, hm1_in;
  logic [IW-1:0]    idx, top_idx;
  logic [PW-1:0]    por_cnt;
  logic [6:0]       len_eff;
  logic             sync1, sync2, smp, err, running, lim_hit;

  always_comb begin
    len_eff = bus.vec_len;
    if (bus.vec_len == 7'd0 || bus.vec_len > 7'(VEC_W)) len_eff = 7'(VEC_W);
    hm1_in  = (bus.half_dly == '0) ? '0 : bus.half_dly - DLY_W'(1);
    top_idx = IW'(len_eff - 7'd1);
    keep    = '0;
    for (int i = 0; i < VEC_W; i++) keep[i] = (7'(i) < len_eff);
  end

  assign running       = (state != ST_IDLE) && (state != ST_DONE);
  assign lim_hit       = ({1'b0, tmo} + (DLY_W+1)'(1)) >= {1'b0, tmo_lim_q};
  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.busy      = running;
  assign bus.done      = (state == ST_DONE);
  assign bus.err       = err;
  assign bus.rx_vec    = rx_vec;

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;  vec <= '0;  mask <= '0;  rx_vec <= '0;
      h_m1 <= '0;  tmo_lim_q <= '0;  cnt <= '0;  tmo <= '0;  idx <= '0;  por_cnt <= '0;
      sync1 <= 1'b0;  sync2 <= 1'b0;  smp <= 1'b0;  err <= 1'b0;
      sdata_out <= 1'b0;  sdata_oe <= 1'b0;  sclk_out <= 1'b0;  sclk_oe <= 1'b0;  vdd_en <= 1'b0;
    end else begin
      sync1 <= sdata_in;
      sync2 <= sync1;
      // Abort overrides whatever transition the running state would take this cycle
      if (bus.abort && running) begin
        state <= ST_DONE;  err <= 1'b1;  sdata_oe <= 1'b0;  sclk_out <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (bus.cmd_valid) begin
            err <= 1'b0;  vec <= bus.vec_in;  mask <= bus.mask_in;  h_m1 <= hm1_in;
            tmo_lim_q <= bus.tmo_lim;  idx <= top_idx;  tmo <= '0;  por_cnt <= '0;  cnt <= hm1_in;
            case (bus.cmd)
              3'd1: begin
                state <= ST_VDD_ON;  vdd_en <= 1'b1;  sclk_oe <= 1'b0;  sdata_oe <= 1'b0;
                sclk_out <= 1'b0;  mask <= '0;
              end
              3'd2: begin
                state <= ST_NOP;  vdd_en <= 1'b0;  sclk_oe <= 1'b0;  sdata_oe <= 1'b0;  sclk_out <= 1'b0;
              end
              3'd3: begin
                state <= ST_SHIFT;  sclk_oe <= 1'b1;  sclk_out <= 1'b1;
                sdata_out <= bus.vec_in[top_idx];  sdata_oe <= ~bus.mask_in[top_idx];
                rx_vec <= rx_vec & keep;
              end
              3'd4: begin
                state <= ST_PRE;  sdata_oe <= 1'b0;  sclk_oe <= 1'b1;  sclk_out <= 1'b1;
                tmo <= DLY_W'(EXEC_CLKS - 1);
              end
              3'd0:    state <= ST_NOP;
              default: begin state <= ST_NOP;  err <= 1'b1; end
            endcase
          end
          ST_VDD_ON:
            if (por_cnt == PW'(POR_WAIT - 1)) state <= ST_WAIT_HI;
            else por_cnt <= por_cnt + PW'(1);
          ST_WAIT_HI, ST_WAIT_LO: begin
            tmo <= tmo + DLY_W'(1);
            if (state == ST_WAIT_HI && sync2) begin
              state <= ST_WAIT_LO;
            end else if (state == ST_WAIT_LO && !sync2) begin
              state <= ST_SHIFT;  sclk_oe <= 1'b1;  sclk_out <= 1'b1;  cnt <= h_m1;
              sdata_oe <= 1'b1;  sdata_out <= vec[idx];
            end else if (tmo == tmo_lim_q) begin
              state <= ST_DONE;  err <= 1'b1;
            end
          end
          ST_SHIFT, ST_PRE, ST_POLL, ST_TRAIL: begin
            if (cnt != '0) begin
              cnt <= cnt - DLY_W'(1);
            end else if (sclk_out) begin
              // Last high cycle: capture the synchronised pin before SCLK falls
              sclk_out <= 1'b0;  cnt <= h_m1;  smp <= sync2;
              if (state == ST_SHIFT && mask[idx]) rx_vec[idx] <= sync2;
            end else begin
              cnt <= h_m1;
              case (state)
                ST_SHIFT:
                  if (idx == '0) begin
                    state <= ST_DONE;  sdata_oe <= 1'b0;
                  end else begin
                    idx <= idx - IW'(1);  sclk_out <= 1'b1;
                    sdata_out <= vec[idx - IW'(1)];  sdata_oe <= ~mask[idx - IW'(1)];
                  end
                ST_PRE: begin
                  sclk_out <= 1'b1;
                  if (tmo == '0) state <= ST_POLL;
                  else tmo <= tmo - DLY_W'(1);
                end
                ST_POLL:
                  if (!smp) begin
                    state <= ST_TRAIL;  sclk_out <= 1'b1;  sdata_oe <= 1'b1;  sdata_out <= 1'b0;
                    tmo <= DLY_W'(EXEC_CLKS - 1);
                  end else if (lim_hit) begin
                    state <= ST_DONE;  err <= 1'b1;
                  end else begin
                    tmo <= tmo + DLY_W'(1);  sclk_out <= 1'b1;
                  end
                default:
                  if (tmo == '0) begin
                    state <= ST_DONE;  sdata_oe <= 1'b0;
                  end else begin
                    tmo <= tmo - DLY_W'(1);  sclk_out <= 1'b1;
                  end
              endcase
            end
          end
          ST_NOP:  state <= ST_DONE;
          ST_DONE: begin state <= ST_IDLE;  sdata_oe <= 1'b0;  sclk_out <= 1'b0; end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_issp_vec_engine.sv
// tb/tb_issp_vec_engine.sv - directed self-checking bench for issp_vec_engine
module tb_issp_vec_engine;
  logic osc = 1'b0;
  logic rst_n = 1'b0;
  logic sdata_in = 1'b0;
  logic sdata_out, sdata_oe, sclk_out, sclk_oe, vdd_en;

  issp_vec_engine_if #(.VEC_W(22), .DLY_W(16)) bus ();

  issp_vec_engine #(.VEC_W(22), .DLY_W(16), .POR_WAIT(60), .EXEC_CLKS(40)) dut (
    .osc(osc), .rst_n(rst_n), .bus(bus), .sdata_in(sdata_in), .sdata_out(sdata_out),
    .sdata_oe(sdata_oe), .sclk_out(sclk_out), .sclk_oe(sclk_oe), .vdd_en(vdd_en)
  );

  initial forever #5 osc = ~osc;

  int n_tests = 0;
  int n_fail = 0;

  // Pin monitor and target model (mode: 0 drive 0, 1 reply resp bits, 2 POR profile, 4 EXEC ready after 5 polls, 5 stuck 1)
  logic        sclk_q = 1'b0;
  logic        rise;
  int          pulses = 0, oe0 = 0, cyc = 0;
  logic [63:0] sd_hist = '0;
  int          mode = 0, base_p = 0, base_o = 0, base_c = 0, len_cur = 22;
  logic [63:0] resp = '0;

  assign rise = sclk_out & ~sclk_q;

  always @(negedge osc) begin
    sclk_q <= sclk_out;
    cyc    <= cyc + 1;
    if (rise) begin
      pulses  <= pulses + 1;
      sd_hist <= {sd_hist[62:0], sdata_out};
      if (!sdata_oe) oe0 <= oe0 + 1;
    end
    case (mode)
      1: if (rise) sdata_in <= resp[6'(len_cur - 1 - (pulses - base_p))];
      2: sdata_in <= (cyc - base_c >= 100) && (cyc - base_c < 200);
      4: if (rise) sdata_in <= (pulses - base_p < 45);
      5: sdata_in <= 1'b1;
      default: sdata_in <= 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [63:0] v, input logic [63:0] m, input int len,
                       input int hd, input int tl, input int md, input logic [63:0] rsp);
    @(negedge osc);
    mode = md;  resp = rsp;  len_cur = (len == 0 || len > 22) ? 22 : len;
    base_p = pulses;  base_o = oe0;  base_c = cyc;
    bus.cmd = c;  bus.vec_in = v[21:0];  bus.mask_in = m[21:0];  bus.vec_len = 7'(len);
    bus.half_dly = 16'(hd);  bus.tmo_lim = 16'(tl);  bus.cmd_valid = 1'b1;
    @(negedge osc);
    bus.cmd_valid = 1'b0;
    chk("busy_after_accept", bus.busy, 1'b1);
    chk("ready_low_after_accept", bus.cmd_ready, 1'b0);
  endtask

  task automatic wait_done(input string tag, input int max, output int n);
    n = 0;
    while (!bus.done && n < max) begin
      @(negedge osc);
      n++;
    end
    chk({tag, "_done"}, bus.done, 1'b1);
  endtask

  int  n, k;
  logic saw;

  initial begin
    bus.cmd_valid = 1'b0;  bus.cmd = '0;  bus.vec_in = '0;  bus.mask_in = '0;  bus.vec_len = '0;
    bus.half_dly = '0;  bus.tmo_lim = '0;  bus.abort = 1'b0;
    repeat (3) @(negedge osc);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_rx", bus.rx_vec, 0);
    chk("rst_pins", {sdata_out, sdata_oe, sclk_out, sclk_oe, vdd_en}, 5'b0);
    @(posedge osc);
    #3 rst_n = 1'b1;
    chk("rst_ready", bus.cmd_ready, 1'b1);

    issue(3'd3, 64'h2AAAAA, 64'h0, 22, 6, 0, 0, 64'h0);
    wait_done("sv_alt", 400, n);
    chk("sv_alt_lat", n, 264);
    chk("sv_alt_err", bus.err, 1'b0);
    chk("sv_alt_pulses", pulses - base_p, 22);
    chk("sv_alt_data", sd_hist[21:0], 22'h2AAAAA);
    chk("sv_alt_sclk_oe", sclk_oe, 1'b1);

    issue(3'd3, 64'h3FFF00, 64'h0000FF, 22, 6, 0, 1, 64'h0000A5);
    wait_done("sv_rx", 400, n);
    chk("sv_rx_vec", bus.rx_vec, 22'h0000A5);
    chk("sv_rx_oe0", oe0 - base_o, 8);

    issue(3'd3, 64'h0, 64'h3F0000, 22, 6, 0, 1, 64'h150000);
    wait_done("sv_rx_hi", 400, n);
    chk("sv_rx_hi_vec", bus.rx_vec, 22'h1500A5);

    issue(3'd3, 64'h0, 64'h00000F, 8, 6, 0, 1, 64'h03);
    wait_done("sv_len8", 200, n);
    chk("sv_len8_clear", bus.rx_vec, 22'h0000A3);
    chk("sv_len8_lat", n, 96);

    issue(3'd3, 64'h00000A, 64'h0, 4, 0, 0, 0, 64'h0);
    wait_done("sv_h0", 50, n);
    chk("sv_h0_lat", n, 8);
    chk("sv_h0_pulses", pulses - base_p, 4);
    chk("sv_h0_data", sd_hist[3:0], 4'hA);

    issue(3'd3, 64'h155555, 64'h0, 0, 1, 0, 0, 64'h0);
    wait_done("sv_len0", 100, n);
    chk("sv_len0_pulses", pulses - base_p, 22);
    chk("sv_len0_data", sd_hist[21:0], 22'h155555);

    issue(3'd3, 64'h0, 64'h0, 30, 1, 0, 0, 64'h0);
    wait_done("sv_len30", 100, n);
    chk("sv_len30_lat", n, 44);

    issue(3'd3, 64'h2AAAAA, 64'h0, 22, 6, 0, 0, 64'h0);
    k = 0;
    while (pulses - base_p < 10 && k < 1000) begin
      @(negedge osc);
      k++;
    end
    chk("abort_reach_cell10", pulses - base_p, 10);
    bus.abort = 1'b1;
    @(negedge osc);
    bus.abort = 1'b0;
    chk("abort_done", bus.done, 1'b1);
    chk("abort_err", bus.err, 1'b1);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_pins", {sdata_oe, sclk_out, vdd_en}, 3'b000);
    @(negedge osc);
    chk("abort_ready", bus.cmd_ready, 1'b1);
    chk("abort_no_more_pulses", pulses - base_p, 10);

    bus.abort = 1'b1;
    @(negedge osc);
    bus.abort = 1'b0;
    @(negedge osc);
    chk("abort_idle_done", bus.done, 1'b0);
    chk("abort_idle_ready", bus.cmd_ready, 1'b1);

    issue(3'd6, 64'h0, 64'h0, 22, 1, 0, 0, 64'h0);
    wait_done("illegal", 10, n);
    chk("illegal_err", bus.err, 1'b1);
    repeat (3) @(negedge osc);
    chk("illegal_err_held", bus.err, 1'b1);

    issue(3'd0, 64'h0, 64'h0, 22, 1, 0, 0, 64'h0);
    wait_done("none", 10, n);
    chk("none_err", bus.err, 1'b0);
    chk("none_pins", {sdata_oe, sclk_out, sclk_oe, vdd_en}, 4'b0010);

    issue(3'd4, 64'h0, 64'h0, 22, 4, 20, 4, 64'h0);
    wait_done("exec", 1000, n);
    chk("exec_pulses", pulses - base_p, 86);
    chk("exec_lat", n, 688);
    chk("exec_err", bus.err, 1'b0);
    chk("exec_pins", {sdata_oe, sclk_out, sclk_oe}, 3'b001);

    issue(3'd4, 64'h0, 64'h0, 22, 4, 10, 5, 64'h0);
    wait_done("exec_tmo", 1000, n);
    chk("exec_tmo_pulses", pulses - base_p, 50);
    chk("exec_tmo_err", bus.err, 1'b1);

    issue(3'd2, 64'h0, 64'h0, 22, 1, 0, 0, 64'h0);
    wait_done("pwroff", 10, n);
    chk("pwroff_lat", n, 1);
    chk("pwroff_pins", {sdata_oe, sclk_oe, vdd_en}, 3'b000);

    issue(3'd1, 64'h3C3C3C, 64'h3FFFFF, 22, 2, 1000, 2, 64'h0);
    chk("por_vdd_on", {vdd_en, sclk_oe, sdata_oe}, 3'b100);
    wait_done("por", 2000, n);
    chk("por_lat", n, 290);
    chk("por_err", bus.err, 1'b0);
    chk("por_pulses", pulses - base_p, 22);
    chk("por_data", sd_hist[21:0], 22'h3C3C3C);
    chk("por_mask_ignored", oe0 - base_o, 0);
    chk("por_vdd_held", vdd_en, 1'b1);

    issue(3'd1, 64'h0, 64'h0, 22, 2, 500, 0, 64'h0);
    wait_done("por_tmo", 2000, n);
    chk("por_tmo_err", bus.err, 1'b1);
    chk("por_tmo_vdd", vdd_en, 1'b1);
    chk("por_tmo_pulses", pulses - base_p, 0);

    issue(3'd1, 64'h0, 64'h0, 22, 2, 500, 0, 64'h0);
    repeat (20) @(negedge osc);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_vdd", vdd_en, 1'b0);
    chk("rst_mid_busy", bus.busy, 1'b0);
    saw = 1'b0;
    repeat (4) begin
      @(negedge osc);
      saw = saw | bus.done;
    end
    @(posedge osc);
    #3 rst_n = 1'b1;
    issue(3'd0, 64'h0, 64'h0, 22, 1, 0, 0, 64'h0);
    wait_done("post_rst", 10, n);
    chk("rst_mid_no_done", saw, 1'b0);
    chk("post_rst_lat", n, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
